// File: rtl/radix2_scheduler_pkg.sv
// Shared definitions for the radix-2 FFT scheduler: FSM states and the
// width of the stage index that drives the butterfly.
package radix2_scheduler_pkg;

    localparam int STAGE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/radix2_scheduler_addr_gen.sv
// Combinational operand/twiddle addressing for butterfly k of stage s in an
// in-place radix-2 FFT: pairs are 2^s apart, groups are 2^(s+1) wide.
module radix2_addr_gen
    import radix2_scheduler_pkg::*;
#(
    parameter int LOG2N = 4
) (
    input  logic [STAGE_W-1:0] stage_i,
    input  logic [LOG2N-2:0]   k_i,
    output logic [LOG2N-1:0]   addr_a_o,
    output logic [LOG2N-1:0]   addr_b_o,
    output logic [LOG2N-2:0]   tw_o
);
    localparam int                 KW    = LOG2N - 1;
    localparam logic [STAGE_W-1:0] KW_S  = STAGE_W'(KW);
    localparam logic [STAGE_W-1:0] ONE_S = STAGE_W'(1);

    logic [KW-1:0] mask;
    logic [KW-1:0] pos;
    logic [KW-1:0] grp;

    // At s = LOG2N-1 the shift clears every bit, so the mask becomes all ones.
    always_comb begin
        mask     = ~({KW{1'b1}} << stage_i);
        pos      = k_i & mask;
        grp      = k_i >> stage_i;
        addr_a_o = ({1'b0, grp} << (stage_i + ONE_S)) | {1'b0, pos};
        addr_b_o = addr_a_o | (LOG2N'(1) << stage_i);
        tw_o     = pos << (KW_S - stage_i);
    end

endmodule

// File: rtl/radix2_scheduler.sv
// Stage/butterfly sequencer for an in-place radix-2 FFT: issues one operand
// pair per cycle, drains the butterfly pipeline between stages.
module radix2_scheduler
    import radix2_scheduler_pkg::*;
#(
    parameter int LOG2N  = 4,
    parameter int BF_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [STAGE_W-1:0] stage_fft,
    output logic               rd_en,
    output logic [LOG2N-1:0]   rd_addr_a,
    output logic [LOG2N-1:0]   rd_addr_b,
    output logic [LOG2N-2:0]   tw_addr,
    output logic               bf_en,
    output logic               bf_delay,
    output logic               wr_en,
    output logic [LOG2N-1:0]   wr_addr_a,
    output logic [LOG2N-1:0]   wr_addr_b
);
    localparam int                 KW     = LOG2N - 1;
    localparam int                 DW     = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [KW-1:0]      K_LAST = {KW{1'b1}};
    localparam logic [KW-1:0]      K_ONE  = KW'(1);
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2N - 1);
    localparam logic [STAGE_W-1:0] S_ONE  = STAGE_W'(1);
    localparam logic [DW-1:0]      D_LAST = DW'(BF_LAT - 1);
    localparam logic [DW-1:0]      D_ONE  = DW'(1);

    state_e             state_q;
    logic [STAGE_W-1:0] s_q;
    logic [KW-1:0]      k_q;
    logic [DW-1:0]      d_q;
    logic               rd_en_q;
    logic               busy_q;
    logic               done_q;
    logic               bf_delay_q;

    logic [LOG2N-1:0]   ag_a;
    logic [LOG2N-1:0]   ag_b;
    logic [KW-1:0]      ag_tw;

    logic               wen_sr_q [BF_LAT];
    logic [LOG2N-1:0]   wa_sr_q  [BF_LAT];
    logic [LOG2N-1:0]   wb_sr_q  [BF_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            k_q        <= '0;
            d_q        <= '0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bf_delay_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_READ;
                        s_q     <= '0;
                        k_q     <= '0;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (k_q == K_LAST) begin
                        state_q    <= ST_DRAIN;
                        d_q        <= '0;
                        rd_en_q    <= 1'b0;
                        bf_delay_q <= 1'b1;
                    end else begin
                        k_q <= k_q + K_ONE;
                    end
                end
                // The drain length equals the write delay, so the last write of
                // this stage lands before the first read of the next one.
                ST_DRAIN: begin
                    if (d_q == D_LAST) begin
                        bf_delay_q <= 1'b0;
                        if (s_q == S_LAST) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_READ;
                            s_q     <= s_q + S_ONE;
                            k_q     <= '0;
                            rd_en_q <= 1'b1;
                        end
                    end else begin
                        d_q <= d_q + D_ONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    radix2_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .stage_i  (s_q),
        .k_i      (k_q),
        .addr_a_o (ag_a),
        .addr_b_o (ag_b),
        .tw_o     (ag_tw)
    );

    // Addresses are held at zero outside READ so idle/reset outputs are clean.
    assign rd_addr_a = rd_en_q ? ag_a  : '0;
    assign rd_addr_b = rd_en_q ? ag_b  : '0;
    assign tw_addr   = rd_en_q ? ag_tw : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BF_LAT; i++) begin
                wen_sr_q[i] <= 1'b0;
                wa_sr_q[i]  <= '0;
                wb_sr_q[i]  <= '0;
            end
        end else begin
            wen_sr_q[0] <= rd_en_q;
            wa_sr_q[0]  <= rd_addr_a;
            wb_sr_q[0]  <= rd_addr_b;
            for (int i = 1; i < BF_LAT; i++) begin
                wen_sr_q[i] <= wen_sr_q[i-1];
                wa_sr_q[i]  <= wa_sr_q[i-1];
                wb_sr_q[i]  <= wb_sr_q[i-1];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage_fft = s_q;
    assign rd_en     = rd_en_q;
    assign bf_en     = rd_en_q;
    assign bf_delay  = bf_delay_q;
    assign wr_en     = wen_sr_q[BF_LAT-1];
    assign wr_addr_a = wa_sr_q[BF_LAT-1];
    assign wr_addr_b = wb_sr_q[BF_LAT-1];

endmodule

// File: tb/tb_radix2_scheduler.sv
// Scoreboard bench for radix2_scheduler: a run-level model queues every
// expected read/write; a negedge monitor pops and compares.
module tb_radix2_scheduler;
    localparam int LOG2N  = 4;
    localparam int BF_LAT = 2;
    localparam int N      = 1 << LOG2N;
    localparam int HALF   = N / 2;
    localparam int P      = HALF + BF_LAT;

    typedef struct {
        int cyc;
        int s;
        int k;
        int a;
        int b;
        int tw;
        bit last;
    } op_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             busy, done, rd_en, bf_en, bf_delay, wr_en;
    logic [3:0]       stage_fft;
    logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [LOG2N-2:0] tw_addr;

    int  cyc       = 0;
    int  checks    = 0;
    int  errors    = 0;
    int  run_t1    = -100;
    int  run_tdone = -100;
    int  seen [N];
    op_t rq[$];
    op_t wq[$];

    radix2_scheduler #(
        .LOG2N  (LOG2N),
        .BF_LAT (BF_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .stage_fft (stage_fft),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .bf_en     (bf_en),
        .bf_delay  (bf_delay),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Reference: butterfly k of stage s pairs index grp*2^(s+1)+pos with the one
    // 2^s above it; reads are back to back, then BF_LAT idle cycles per stage.
    task automatic issue_run(input int c);
        op_t e;
        int  t1;
        t1 = c + 1;
        for (int s = 0; s < LOG2N; s++) begin
            for (int k = 0; k < HALF; k++) begin
                e.cyc  = t1 + s * P + k;
                e.s    = s;
                e.k    = k;
                e.a    = (k / (2 ** s)) * (2 ** (s + 1)) + (k % (2 ** s));
                e.b    = e.a + 2 ** s;
                e.tw   = (k % (2 ** s)) * (2 ** (LOG2N - 1 - s));
                e.last = (k == HALF - 1);
                rq.push_back(e);
                e.cyc  = e.cyc + BF_LAT;
                wq.push_back(e);
            end
        end
        run_t1    = t1;
        run_tdone = t1 + LOG2N * P;
    endtask

    task automatic step(input bit st, input bit rst);
        if (rst) begin
            rst_n = 1'b0;
            start = 1'b0;
            rq.delete();
            wq.delete();
            run_t1    = -100;
            run_tdone = -100;
        end else begin
            rst_n = 1'b1;
            start = st;
            if (st && cyc > run_tdone) issue_run(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        bit  has;
        op_t e;
        int  rel;
        int  bad;
        if (!rst_n) begin
            chk("reset_outputs", int'(busy) + int'(done) + int'(rd_en) + int'(bf_en) +
                int'(bf_delay) + int'(wr_en) + int'(stage_fft) + int'(rd_addr_a) +
                int'(rd_addr_b) + int'(tw_addr) + int'(wr_addr_a) + int'(wr_addr_b), 0);
            for (int i = 0; i < N; i++) seen[i] = 0;
        end else begin
            has = (rq.size() > 0) && (rq[0].cyc == cyc);
            chk("rd_en", int'(rd_en), int'(has));
            chk("bf_en", int'(bf_en), int'(has));
            if (has) begin
                e = rq.pop_front();
                if (rd_en) begin
                    chk("rd_addr_a", int'(rd_addr_a), e.a);
                    chk("rd_addr_b", int'(rd_addr_b), e.b);
                    chk("tw_addr", int'(tw_addr), e.tw);
                    chk("stage_fft", int'(stage_fft), e.s);
                    if (e.s == 0 && e.k == 3) begin
                        chk("s0k3_a", int'(rd_addr_a), 6);
                        chk("s0k3_b", int'(rd_addr_b), 7);
                        chk("s0k3_tw", int'(tw_addr), 0);
                    end
                    if (e.s == 2 && e.k == 5) begin
                        chk("s2k5_a", int'(rd_addr_a), 9);
                        chk("s2k5_b", int'(rd_addr_b), 13);
                        chk("s2k5_tw", int'(tw_addr), 2);
                    end
                    if (e.s == 3 && e.k == 7) begin
                        chk("s3k7_a", int'(rd_addr_a), 7);
                        chk("s3k7_b", int'(rd_addr_b), 15);
                        chk("s3k7_tw", int'(tw_addr), 7);
                    end
                    seen[int'(rd_addr_a)]++;
                    seen[int'(rd_addr_b)]++;
                    if (e.last) begin
                        bad = 0;
                        for (int i = 0; i < N; i++) begin
                            if (seen[i] != 1) bad++;
                            seen[i] = 0;
                        end
                        chk("stage_permutation", bad, 0);
                    end
                end
            end
            has = (wq.size() > 0) && (wq[0].cyc == cyc);
            chk("wr_en", int'(wr_en), int'(has));
            if (has) begin
                e = wq.pop_front();
                if (wr_en) begin
                    chk("wr_addr_a", int'(wr_addr_a), e.a);
                    chk("wr_addr_b", int'(wr_addr_b), e.b);
                end
            end
            chk("done", int'(done), int'(cyc == run_tdone));
            chk("busy", int'(busy), int'(cyc >= run_t1 && cyc <= run_tdone));
            rel = cyc - run_t1;
            if (rel >= 0 && rel < LOG2N * P) begin
                chk("bf_delay", int'(bf_delay), int'((rel % P) >= HALF));
                chk("stage_hold", int'(stage_fft), rel / P);
            end else begin
                chk("bf_delay_idle", int'(bf_delay), 0);
            end
        end
    end

    initial begin
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        // Single start pulse: one complete run.
        step(1'b1, 1'b0);
        repeat (50) step(1'b0, 1'b0);
        // Start held high: must be ignored while busy and during DONE.
        repeat (60) step(1'b1, 1'b0);
        repeat (50) step(1'b0, 1'b0);
        // Reset twenty cycles into a run, then a fresh run.
        step(1'b1, 1'b0);
        repeat (19) step(1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (50) step(1'b0, 1'b0);
        // Random starts with occasional resets.
        repeat (3000) begin
            if ($urandom_range(0, 399) == 0) step(1'b0, 1'b1);
            else step($urandom_range(0, 7) == 0, 1'b0);
        end
        repeat (60) step(1'b0, 1'b0);
        chk("rd_queue_empty", rq.size(), 0);
        chk("wr_queue_empty", wq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
